// File: rtl/icache_dm_if.sv
// Fetch request/response and line-fill memory handshake for icache_dm.
// slave = cache side, master = core fetch + memory side.
interface icache_dm_if #(
  parameter int LINE_BYTES = 16
);
  logic                    req_valid;
  logic [31:0]             req_addr;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [31:0]             rsp_data;
  logic                    flush;
  logic [31:0]             mem_addr;
  logic                    mem_strobe;
  logic                    mem_read;
  logic                    mem_write;
  logic [LINE_BYTES*8-1:0] mem_wdata;
  logic [LINE_BYTES*8-1:0] mem_rdata;
  logic                    mem_read_complete;

  modport slave (
    input  req_valid, req_addr, flush, mem_rdata, mem_read_complete,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_strobe, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_addr, flush, mem_rdata, mem_read_complete,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_strobe, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only I-cache: hit answers the cycle after accept; miss adds FILL_REQ + memory time + re-lookup.
// Responses have no backpressure; req_ready drops on misses, during fills and while a flush is pending.
module icache_dm #(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  icache_dm_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT} state_t;

  state_t               state_q, state_nxt;
  addr_t                req_q;
  logic                 flush_pend_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_store  [NUM_LINES];
  logic [LINE_W-1:0]    data_store [NUM_LINES];
  logic                 mem_strobe_q;
  logic [31:0]          mem_addr_q;

  logic                 flush_any;
  logic                 hit;
  logic                 ready_c;
  logic                 rsp_valid_c;
  logic                 accept;
  logic                 do_flush;
  logic                 fill_done;
  logic [LINE_W-1:0]    line_rd;
  logic [OFF_W+2:0]     word_shift;
  logic [31:0]          word_rd;

  assign flush_any  = bus.flush | flush_pend_q;
  assign line_rd    = data_store[req_q.idx];
  assign hit        = (state_q == LOOKUP) && valid_q[req_q.idx] && (tag_store[req_q.idx] == req_q.tag);
  // Byte offset rounded down to a word, scaled to a bit position (little-endian lanes).
  assign word_shift = {req_q.off & WORD_MASK, 3'b000};
  assign word_rd    = 32'(line_rd >> word_shift);
  assign accept     = ready_c & bus.req_valid;

  always_comb begin
    state_nxt   = state_q;
    ready_c     = 1'b0;
    rsp_valid_c = 1'b0;
    do_flush    = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_any) begin
          do_flush = 1'b1;
        end else begin
          ready_c = 1'b1;
          if (bus.req_valid) state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          rsp_valid_c = 1'b1;
          if (!flush_any) begin
            ready_c = 1'b1;
            if (!bus.req_valid) state_nxt = IDLE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = FILL_REQ;
        end
      end
      FILL_REQ: state_nxt = FILL_WAIT;
      FILL_WAIT: begin
        if (bus.mem_read_complete) begin
          fill_done = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      mem_strobe_q <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (accept) req_q <= addr_t'(bus.req_addr);
      // A flush seen outside IDLE waits until the current request has been answered.
      if (do_flush)                           flush_pend_q <= 1'b0;
      else if (bus.flush && state_q != IDLE)  flush_pend_q <= 1'b1;
      if (do_flush)       valid_q              <= '0;
      else if (fill_done) valid_q[req_q.idx]   <= 1'b1;
      mem_strobe_q <= (state_nxt == FILL_REQ);
      if (state_nxt == FILL_REQ) mem_addr_q <= {req_q.tag, req_q.idx, OFF_W'(0)};
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_store[req_q.idx]  <= req_q.tag;
      data_store[req_q.idx] <= bus.mem_rdata;
    end
  end

  assign bus.req_ready  = ready_c & rst;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_data   = rsp_valid_c ? word_rd : 32'h0;
  assign bus.mem_strobe = mem_strobe_q;
  assign bus.mem_read   = mem_strobe_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = '0;
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: vector table, corner sequences, and randomized traffic against a line-number model.
`timescale 1ns/1ps
module tb_icache_dm;
  localparam int LINE_BYTES = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_dm_if #(.LINE_BYTES(LINE_BYTES)) bus ();
  icache_dm #(.LINE_BYTES(LINE_BYTES), .NUM_LINES(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Memory image: a mixed hash of the address so different lines hold different bytes.
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return 8'(a[7:0] + 8'd37 * (a[15:8] - 8'd1) + 8'd11 * a[23:16] + 8'd3 * a[31:24]);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] al;
    al = a & ~32'h3;
    return {mbyte(al + 32'd3), mbyte(al + 32'd2), mbyte(al + 32'd1), mbyte(al)};
  endfunction

  function automatic logic [LINE_BYTES*8-1:0] line_of(input logic [31:0] l);
    logic [LINE_BYTES*8-1:0] v;
    v = '0;
    for (int i = 0; i < LINE_BYTES; i++) v[8*i +: 8] = mbyte(l + 32'(i));
    return v;
  endfunction

  // Memory model: answers each strobe after mem_lat extra cycles with a one-cycle completion.
  int          mem_lat    = 1;
  int          fill_count = 0;
  logic [31:0] last_fill_addr = '0;
  bit          mem_busy   = 1'b0;
  int          mem_cnt    = 0;
  logic [31:0] mem_cur    = '0;

  always @(negedge clk) begin
    bus.mem_read_complete = 1'b0;
    if (!rst) begin
      mem_busy      = 1'b0;
      bus.mem_rdata = '0;
    end else if (mem_busy) begin
      if (bus.mem_strobe) check("strobe_while_busy", 32'(bus.mem_strobe), 0);
      if (mem_cnt == 0) begin
        bus.mem_rdata         = line_of(mem_cur);
        bus.mem_read_complete = 1'b1;
        mem_busy              = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (bus.mem_strobe) begin
      fill_count++;
      last_fill_addr = bus.mem_addr;
      mem_cur        = bus.mem_addr;
      mem_cnt        = mem_lat;
      mem_busy       = 1'b1;
      check("mem_read_eq_strobe", 32'(bus.mem_read), 1);
      check("mem_write_zero", 32'(bus.mem_write), 0);
      check("mem_wdata_zero", 32'(|bus.mem_wdata), 0);
    end
  end

  // Present a request, wait for acceptance and the response; optionally pulse flush in cycle flush_cyc after accept.
  task automatic issue(input logic [31:0] addr, input int flush_cyc,
                       output logic [31:0] data, output int lat, output int nfill, output bit ok);
    int f0;
    int w;
    bit rdy;
    f0   = fill_count;
    ok   = 1'b0;
    data = '0;
    lat  = 0;
    w    = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    do begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk); #1;
      w++;
    end while (!rdy && w < 50);
    bus.req_valid = 1'b0;
    check("accepted", 32'(rdy), 1);
    while (rdy && !ok && lat < 200) begin
      lat++;
      bus.flush = (lat == flush_cyc);
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok   = 1'b1;
        data = bus.rsp_data;
      end
      @(posedge clk); #1;
    end
    bus.flush = 1'b0;
    check("rsp_seen", 32'(ok), 1);
    nfill = fill_count - f0;
  endtask

  task automatic run_req(input string name, input logic [31:0] addr, input int fc,
                         input bit exp_hit, input logic [31:0] exp_data);
    logic [31:0] d;
    int lat;
    int nf;
    bit ok;
    issue(addr, fc, d, lat, nf, ok);
    check({name, "_data"}, d, exp_data);
    check({name, "_latency"}, lat, exp_hit ? 1 : mem_lat + 4);
    check({name, "_fills"}, nf, exp_hit ? 0 : 1);
    if (!exp_hit) check({name, "_fill_addr"}, last_fill_addr, addr & ~32'hF);
    @(negedge clk);
    check({name, "_rsp_one_cycle"}, 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          flush_before;
    bit          exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] s_addr [4];
  bit          mv [64];
  logic [27:0] ml [64];

  initial begin : main
    int f0;
    int w;
    bit seen;
    logic [31:0] a;
    int idx;
    bit hit_e;
    int fc;

    vecs[0]  = '{32'h0000_0104, 1'b0, 1'b0, 32'h0706_0504};
    vecs[1]  = '{32'h0000_010C, 1'b0, 1'b1, 32'h0F0E_0D0C};
    vecs[2]  = '{32'h0000_0500, 1'b0, 1'b0, 32'h9796_9594};
    vecs[3]  = '{32'h0000_0100, 1'b0, 1'b0, 32'h0302_0100};
    vecs[4]  = '{32'h0000_0108, 1'b0, 1'b1, 32'h0B0A_0908};
    vecs[5]  = '{32'h0000_0204, 1'b0, 1'b0, 32'h2C2B_2A29};
    vecs[6]  = '{32'h0000_010C, 1'b0, 1'b1, 32'h0F0E_0D0C};
    vecs[7]  = '{32'h0000_020F, 1'b0, 1'b1, 32'h3433_3231};
    vecs[8]  = '{32'h0000_0100, 1'b1, 1'b0, 32'h0302_0100};
    vecs[9]  = '{32'h0000_01FC, 1'b0, 1'b0, 32'hFFFE_FDFC};
    vecs[10] = '{32'h0000_01F0, 1'b0, 1'b1, 32'hF3F2_F1F0};
    vecs[11] = '{32'h8000_0104, 1'b0, 1'b0, 32'h8786_8584};
    vecs[12] = '{32'h0000_0104, 1'b0, 1'b0, 32'h0706_0504};
    s_addr   = '{32'h100, 32'h104, 32'h108, 32'h10C};

    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h104;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_mem_strobe", 32'(bus.mem_strobe), 0);
    check("rst_mem_read", 32'(bus.mem_read), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      mem_lat = i % 3;
      if (vecs[i].flush_before) flush_pulse();
      run_req($sformatf("vec%0d", i), vecs[i].addr, 0, vecs[i].exp_hit, vecs[i].exp_data);
    end

    // Back-to-back hits on the resident 0x100 line.
    f0 = fill_count;
    bus.req_valid = 1'b1;
    bus.req_addr  = s_addr[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stream_ready", 32'(bus.req_ready), 1);
      if (k > 0) begin
        check("stream_rsp_valid", 32'(bus.rsp_valid), 1);
        check("stream_data", bus.rsp_data, word_of(s_addr[k-1]));
      end
      @(posedge clk); #1;
      if (k < 3) bus.req_addr = s_addr[k+1];
      else       bus.req_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_rsp_valid_last", 32'(bus.rsp_valid), 1);
    check("stream_data_last", bus.rsp_data, word_of(s_addr[3]));
    @(posedge clk); #1;
    check("stream_no_fill", fill_count - f0, 0);

    // Flush during FILL_WAIT: response still delivered, then everything is invalid.
    mem_lat = 3;
    run_req("flush_fill", 32'h300, 3, 1'b0, word_of(32'h300));
    run_req("flush_fill_refetch", 32'h300, 0, 1'b0, word_of(32'h300));
    run_req("flush_fill_other", 32'h104, 0, 1'b0, word_of(32'h104));

    // Flush and request together in IDLE: flush wins.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h108;
    bus.flush     = 1'b1;
    @(negedge clk);
    check("flush_wins_ready", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    run_req("flush_wins", 32'h108, 0, 1'b0, word_of(32'h108));

    // Reset in the middle of a fill.
    mem_lat = 1;
    run_req("pre_reset", 32'h010, 0, 1'b0, word_of(32'h010));
    mem_lat = 5;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h400;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    w    = 0;
    while (!seen && w < 20) begin
      @(negedge clk);
      seen = bus.mem_strobe;
      w++;
    end
    check("strobe_before_reset", 32'(seen), 1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("midfill_req_ready", 32'(bus.req_ready), 0);
    check("midfill_rsp_valid", 32'(bus.rsp_valid), 0);
    check("midfill_mem_strobe", 32'(bus.mem_strobe), 0);
    check("midfill_mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    mem_lat = 2;
    run_req("post_reset_same", 32'h400, 0, 1'b0, word_of(32'h400));
    run_req("post_reset_old", 32'h010, 0, 1'b0, word_of(32'h010));
    run_req("post_reset_hit", 32'h014, 0, 1'b1, word_of(32'h014));

    // Randomized traffic against a model holding the resident line number per index.
    flush_pulse();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    for (int i = 0; i < 250; i++) begin
      a = (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 3)) << 10)
        | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      mem_lat = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) begin
        flush_pulse();
        for (int j = 0; j < 64; j++) mv[j] = 1'b0;
      end
      idx   = int'(a[9:4]);
      hit_e = mv[idx] && (ml[idx] == a[31:4]);
      fc    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, hit_e ? 1 : mem_lat + 4)) : 0;
      run_req("rand", a, fc, hit_e, word_of(a));
      mv[idx] = 1'b1;
      ml[idx] = a[31:4];
      if (fc != 0) for (int j = 0; j < 64; j++) mv[j] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1);
  end
endmodule
